// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the scanned 7-segment driver.
//   HEX_FONT      : abcdefg patterns (bit 6 = a) indexed by nibble value
//   SEG_OFF       : segment pattern for a dark digit, before polarity
//   lz_blank_mask : per-digit leading-zero blank flags (up to 8 digits)
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Entry 15 first so that HEX_FONT[n] is the glyph for nibble n.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  // Bit k set when nibbles k..digits-1 are all zero (k > 0). Walks from
  // the most significant digit down, tracking an unbroken run of zeros.
  function automatic logic [7:0] lz_blank_mask(input logic [31:0] nibs,
                                               input int digits);
    logic [7:0] m;
    logic       zero_run;
    m        = '0;
    zero_run = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      if (k < digits) begin
        zero_run = zero_run && (nibs[4*k +: 4] == 4'h0);
        m[k]     = zero_run;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Register-side / pin-side bundle of the scanned display driver.
//   value_i/dp_i : frame to show, captured on load_i
//   load_i       : single-cycle capture strobe
//   enable_i     : display on
//   abcdefg_o, dp_o, digit_o : registered display pins
//   pending_o    : a captured frame is waiting for the frame boundary
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
) ();
  logic [DIGITS-1:0][3:0] value_i;
  logic [DIGITS-1:0]      dp_i;
  logic                   load_i;
  logic                   enable_i;
  logic [6:0]             abcdefg_o;
  logic                   dp_o;
  logic [DIGITS-1:0]      digit_o;
  logic                   pending_o;

  modport master (
    output value_i, dp_i, load_i, enable_i,
    input  abcdefg_o, dp_o, digit_o, pending_o
  );

  modport slave (
    input  value_i, dp_i, load_i, enable_i,
    output abcdefg_o, dp_o, digit_o, pending_o
  );
endinterface

// File: rtl/seg7_scan_driver_hex_font.sv
// Nibble to abcdefg decoder (active-high, bit 6 = a).
//   nibble : hex digit value
//   seg    : segment pattern
module seg7_hex_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX_FONT[nibble];
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a DIGITS-wide common-segment 7-segment
// display. A shadow frame is loaded at any time and copied to the
// displayed frame only at a frame boundary (or at once while disabled),
// so a scan never mixes two values.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of seg7_scan_driver_if (value/dp/load/enable
//                in, segment/dp/digit pins and pending flag out)
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter bit LZ_BLANK       = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]          presc;
  logic [IW-1:0]          idx;
  logic [DIGITS-1:0][3:0] shadow_val, disp_val;
  logic [DIGITS-1:0]      shadow_dp, disp_dp;
  logic                   pending;

  logic slot_end, frame_wrap, commit;

  assign slot_end   = bus.enable_i && (presc == PRESC_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);
  // While disabled there is no scan to tear, so a pending frame goes
  // straight through.
  assign commit     = pending && (frame_wrap || !bus.enable_i);

  // Prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (!bus.enable_i) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Shadow / display frames. On a load that lands on a commit the
  // display takes the old shadow and the new value stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      if (commit) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end
      if (bus.load_i) begin
        shadow_val <= bus.value_i;
        shadow_dp  <= bus.dp_i;
      end
      if (bus.load_i)  pending <= 1'b1;
      else if (commit) pending <= 1'b0;
    end
  end

  // Single shared decoder: only the scanned digit needs a glyph.
  logic [3:0] cur_nib;
  logic [6:0] cur_seg;
  logic [7:0] lz_full;

  assign cur_nib = disp_val[idx];
  assign lz_full = lz_blank_mask(32'(disp_val), DIGITS);

  seg7_hex_font u_font (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  logic              show, blank;
  logic [6:0]        seg_nxt;
  logic              dp_nxt;
  logic [DIGITS-1:0] dig_nxt;

  // presc == 0 is the anti-ghost gap: everything dark for one cycle
  // while the digit enable changes over.
  always_comb begin
    show    = bus.enable_i && (presc != '0);
    blank   = LZ_BLANK && lz_full[3'(idx)];
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b0;
    dig_nxt = '0;
    if (show) begin
      seg_nxt = blank ? SEG_OFF : cur_seg;
      dp_nxt  = disp_dp[idx];
      dig_nxt = DIGITS'(1) << idx;
    end
  end

  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] dig_q;

  // Polarity applied here so reset lands on the inactive pin levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= {7{SEG_ACTIVE_LOW}};
      dp_q  <= SEG_ACTIVE_LOW;
      dig_q <= {DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      seg_q <= seg_nxt ^ {7{SEG_ACTIVE_LOW}};
      dp_q  <= dp_nxt ^ SEG_ACTIVE_LOW;
      dig_q <= dig_nxt ^ {DIGITS{DIG_ACTIVE_LOW}};
    end
  end

  assign bus.abcdefg_o = seg_q;
  assign bus.dp_o      = dp_q;
  assign bus.digit_o   = dig_q;
  assign bus.pending_o = pending;

endmodule
